// File: rtl/err_report_arb.sv
// err_report_arb: captures rising edges of a priority-ordered error vector into
// sticky pending/overflow registers and reports pending errors one at a time,
// highest index first, over a valid/ready channel. irq is high while anything
// is pending.
module err_report_arb #(
   parameter int NUM_ERR = 32,
   parameter int IDX_W   = $clog2(NUM_ERR)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_ERR-1:0] err_in,
   input  logic               clr_all,
   input  logic               rpt_ready,
   output logic               rpt_valid,
   output logic [IDX_W-1:0]   rpt_idx,
   output logic               rpt_ovf,
   output logic [NUM_ERR-1:0] pend,
   output logic               irq
);

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   state_t               state_q, state_d;

   logic [NUM_ERR-1:0]   err_q;
   logic [NUM_ERR-1:0]   pend_q, pend_d;
   logic [NUM_ERR-1:0]   ovf_q, ovf_d;
   logic                 rpt_valid_q, rpt_valid_d;
   logic [IDX_W-1:0]     rpt_idx_q, rpt_idx_d;
   logic                 rpt_ovf_q, rpt_ovf_d;

   logic [NUM_ERR-1:0]   ev;
   logic [NUM_ERR-1:0]   clr_vec;
   logic                 hs;
   logic                 sel_go;
   logic [IDX_W-1:0]     sel_idx;

   // Highest set bit of v (bit NUM_ERR-1 has top priority); 0 when v is empty.
   function automatic logic [IDX_W-1:0] top_idx(input logic [NUM_ERR-1:0] v);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_ERR; i++) begin
         if (v[i]) r = IDX_W'(i);
      end
      return r;
   endfunction

   // State register plus all sticky/report flops; everything clears at once on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         err_q       <= '0;
         pend_q      <= '0;
         ovf_q       <= '0;
         rpt_valid_q <= 1'b0;
         rpt_idx_q   <= '0;
         rpt_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         err_q       <= err_in;
         pend_q      <= pend_d;
         ovf_q       <= ovf_d;
         rpt_valid_q <= rpt_valid_d;
         rpt_idx_q   <= rpt_idx_d;
         rpt_ovf_q   <= rpt_ovf_d;
      end
   end

   // Edge detect, handshake decode and the pending/overflow update.
   // A new event always wins over a clear, and a cleared bit never carries
   // overflow into its fresh occurrence.
   always_comb begin
      ev      = err_in & ~err_q;
      hs      = rpt_valid_q & rpt_ready & ~clr_all;
      clr_vec = '0;
      if (clr_all) begin
         clr_vec = '1;
      end else if (hs) begin
         clr_vec = {{(NUM_ERR-1){1'b0}}, 1'b1} << rpt_idx_q;
      end
      pend_d  = (pend_q & ~clr_vec) | ev;
      ovf_d   = (ovf_q | (ev & pend_q)) & ~clr_vec;
      sel_go  = (state_q == IDLE) && (pend_q != '0) && !clr_all;
      sel_idx = top_idx(pend_q);
   end

   // Next-state logic: select from IDLE, leave PRESENT on handshake or abort.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (sel_go) state_d = PRESENT;
         PRESENT: if (clr_all || rpt_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Report outputs: captured at selection and held until the report ends.
   // rpt_ovf is a snapshot; an overflow arriving during PRESENT is dropped by
   // the handshake that clears the bit.
   always_comb begin
      rpt_valid_d = rpt_valid_q;
      rpt_idx_d   = rpt_idx_q;
      rpt_ovf_d   = rpt_ovf_q;
      if (sel_go) begin
         rpt_valid_d = 1'b1;
         rpt_idx_d   = sel_idx;
         rpt_ovf_d   = ovf_q[sel_idx];
      end else if (state_q == PRESENT && (clr_all || rpt_ready)) begin
         rpt_valid_d = 1'b0;
      end
   end

   assign rpt_valid = rpt_valid_q;
   assign rpt_idx   = rpt_idx_q;
   assign rpt_ovf   = rpt_ovf_q;
   assign pend      = pend_q;
   assign irq       = |pend_q;

endmodule

// File: tb/tb_err_report_arb.sv
// Bench for err_report_arb: directed scenarios plus random traffic, all
// checked against a per-bit behavioural model of the pending/report rules.
module tb_err_report_arb;
   localparam int NUM_ERR = 32;
   localparam int IDX_W   = 5;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [NUM_ERR-1:0] err_in = '0;
   logic               clr_all = 1'b0;
   logic               rpt_ready = 1'b0;
   logic               rpt_valid;
   logic [IDX_W-1:0]   rpt_idx;
   logic               rpt_ovf;
   logic [NUM_ERR-1:0] pend;
   logic               irq;

   err_report_arb #(.NUM_ERR(NUM_ERR), .IDX_W(IDX_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .err_in    (err_in),
      .clr_all   (clr_all),
      .rpt_ready (rpt_ready),
      .rpt_valid (rpt_valid),
      .rpt_idx   (rpt_idx),
      .rpt_ovf   (rpt_ovf),
      .pend      (pend),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   bit m_pend [NUM_ERR];
   bit m_ovf  [NUM_ERR];
   bit m_prev [NUM_ERR];
   bit m_valid;
   int m_idx;
   bit m_rovf;

   // Report bookkeeping for bit 9
   int cnt9;
   bit ovf9_seen;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] m_pend_vec();
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < NUM_ERR; i++) v[i] = m_pend[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NUM_ERR; i++) begin
         m_pend[i] = 0;
         m_ovf[i]  = 0;
         m_prev[i] = 0;
      end
      m_valid = 0;
      m_idx   = 0;
      m_rovf  = 0;
   endtask

   // One clock edge of the rules, using the inputs present during the cycle.
   task automatic model_step();
      bit old_pend [NUM_ERR];
      bit old_ovf  [NUM_ERR];
      bit handshake;
      bit any;
      int top;
      handshake = m_valid && rpt_ready && !clr_all;
      any = 0;
      top = 0;
      for (int i = 0; i < NUM_ERR; i++) begin
         old_pend[i] = m_pend[i];
         old_ovf[i]  = m_ovf[i];
         if (m_pend[i]) begin
            any = 1;
            top = i;
         end
      end
      for (int i = 0; i < NUM_ERR; i++) begin
         bit event_i;
         bit cleared;
         event_i = err_in[i] && !m_prev[i];
         cleared = clr_all || (handshake && i == m_idx);
         if (event_i)      m_pend[i] = 1;
         else if (cleared) m_pend[i] = 0;
         if (cleared)                       m_ovf[i] = 0;
         else if (event_i && old_pend[i])   m_ovf[i] = 1;
         m_prev[i] = err_in[i];
      end
      if (m_valid) begin
         if (clr_all || handshake) m_valid = 0;
      end else if (any && !clr_all) begin
         m_valid = 1;
         m_idx   = top;
         m_rovf  = old_ovf[top];
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".valid"}, 32'(rpt_valid), 32'(m_valid));
      chk({tag, ".pend"},  pend, m_pend_vec());
      chk({tag, ".irq"},   32'(irq), 32'(m_pend_vec() != 0));
      if (m_valid) begin
         chk({tag, ".idx"}, 32'(rpt_idx), 32'(m_idx));
         chk({tag, ".ovf"}, 32'(rpt_ovf), 32'(m_rovf));
      end
   endtask

   task automatic tick(input string tag);
      if (rpt_valid && rpt_ready && !clr_all && rpt_idx == 5'd9) begin
         cnt9++;
         ovf9_seen = ovf9_seen | rpt_ovf;
      end
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
   endtask

   initial begin
      model_reset();
      cnt9 = 0;
      ovf9_seen = 0;

      // Reset values
      #1;
      chk("rst.valid", 32'(rpt_valid), 32'd0);
      chk("rst.idx",   32'(rpt_idx),   32'd0);
      chk("rst.ovf",   32'(rpt_ovf),   32'd0);
      chk("rst.pend",  pend,           32'd0);
      chk("rst.irq",   32'(irq),       32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tick("idle");

      // Two pending bits served in priority order with ready held
      rpt_ready = 1'b1;
      err_in = 32'h0000_0044;
      tick("t1.k");
      chk("t1.pend_k", pend, 32'h44);
      chk("t1.irq_k",  32'(irq), 32'd1);
      tick("t1.k1");
      chk("t1.valid6", 32'(rpt_valid), 32'd1);
      chk("t1.idx6",   32'(rpt_idx),   32'd6);
      chk("t1.ovf6",   32'(rpt_ovf),   32'd0);
      tick("t1.k2");
      chk("t1.pend_k2", pend, 32'h04);
      tick("t1.k3");
      chk("t1.idx2", 32'(rpt_idx), 32'd2);
      tick("t1.k4");
      chk("t1.pend_k4", pend, 32'h0);
      chk("t1.irq_k4",  32'(irq), 32'd0);
      err_in = '0;
      tick("t1.end");

      // Stall with ready low, then next bit follows
      rpt_ready = 1'b0;
      err_in = 32'hC000_0000;
      tick("t2.set");
      for (int i = 0; i < 10; i++) begin
         tick("t2.hold");
         chk("t2.hold_valid", 32'(rpt_valid), 32'd1);
         chk("t2.hold_idx",   32'(rpt_idx),   32'd31);
      end
      rpt_ready = 1'b1;
      tick("t2.hs31");
      tick("t2.sel30");
      chk("t2.idx30", 32'(rpt_idx), 32'd30);
      tick("t2.hs30");
      err_in = '0;
      tick("t2.end");

      // Overflow on bit 9 while a higher-priority report is presented
      rpt_ready = 1'b0;
      err_in = (32'h1 << 31) | (32'h1 << 9);
      tick("t3.set");
      tick("t3.p31");
      err_in = 32'h1 << 31;
      tick("t3.low");
      err_in = (32'h1 << 31) | (32'h1 << 9);
      tick("t3.again");
      rpt_ready = 1'b1;
      tick("t3.hs31");
      tick("t3.sel9");
      chk("t3.idx9", 32'(rpt_idx), 32'd9);
      chk("t3.ovf9", 32'(rpt_ovf), 32'd1);
      tick("t3.hs9");
      err_in = '0;
      tick("t3.end");

      // Held level counts once
      cnt9 = 0;
      ovf9_seen = 0;
      err_in = 32'h1 << 9;
      repeat (20) tick("t4.hold");
      err_in = '0;
      repeat (3) tick("t4.tail");
      chk("t4.count9", 32'(cnt9), 32'd1);
      chk("t4.ovf9",   32'(ovf9_seen), 32'd0);

      // Event coinciding with its own handshake
      rpt_ready = 1'b0;
      err_in = 32'h1 << 4;
      tick("t5.set");
      tick("t5.p4");
      err_in = '0;
      tick("t5.low");
      err_in = 32'h1 << 4;
      rpt_ready = 1'b1;
      tick("t5.hs_ev");
      chk("t5.pend4", pend, 32'h10);
      tick("t5.sel4");
      chk("t5.valid4", 32'(rpt_valid), 32'd1);
      chk("t5.idx4",   32'(rpt_idx),   32'd4);
      chk("t5.ovf4",   32'(rpt_ovf),   32'd0);
      tick("t5.hs4");
      err_in = '0;
      tick("t5.end");
      chk("t5.pend0", pend, 32'h0);

      // clr_all during PRESENT with everything pending; bit 3 edge survives
      rpt_ready = 1'b0;
      err_in = 32'hFFFF_FFFF;
      tick("t6.set");
      err_in = 32'hFFFF_FFF7;
      tick("t6.p31");
      err_in = 32'hFFFF_FFFF;
      clr_all = 1'b1;
      tick("t6.clr");
      chk("t6.valid0", 32'(rpt_valid), 32'd0);
      chk("t6.pend8",  pend, 32'h8);
      clr_all = 1'b0;
      rpt_ready = 1'b1;
      tick("t6.sel3");
      chk("t6.idx3", 32'(rpt_idx), 32'd3);
      tick("t6.hs3");
      err_in = '0;
      tick("t6.end");

      // Random traffic
      for (int c = 0; c < 1500; c++) begin
         for (int b = 0; b < NUM_ERR; b++) begin
            if ($urandom_range(0, 15) == 0) err_in[b] = ~err_in[b];
         end
         rpt_ready = ($urandom_range(0, 3) != 0);
         clr_all   = ($urandom_range(0, 40) == 0);
         tick("rnd");
      end
      clr_all = 1'b0;

      // Asynchronous reset during PRESENT
      rpt_ready = 1'b0;
      err_in = '0;
      tick("t7.zero");
      err_in = 32'h1 << 5;
      tick("t7.set");
      tick("t7.p5");
      chk("t7.valid_pre", 32'(rpt_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t7.valid", 32'(rpt_valid), 32'd0);
      chk("t7.idx",   32'(rpt_idx),   32'd0);
      chk("t7.ovf",   32'(rpt_ovf),   32'd0);
      chk("t7.pend",  pend,           32'd0);
      chk("t7.irq",   32'(irq),       32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      rpt_ready = 1'b1;
      repeat (4) tick("t7.after");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
